// File: rtl/alu_mul_sequencer.sv
// Unsigned WORD x WORD -> 2*WORD shift-add multiplier borrowing the shared ALU for its ADD steps.
// One step per granted RUN cycle. A withdrawn grant stalls the step. An abort drops the request immediately.
module alu_mul_sequencer #(
  parameter int         WORD   = 16,
  parameter logic [3:0] OP_ADD = 4'd0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [WORD-1:0] op_a,
  input  logic [WORD-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] prod_hi,
  output logic [WORD-1:0] prod_lo,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [3:0]      alu_op,
  output logic [WORD-1:0] alu_a,
  output logic [WORD-1:0] alu_b,
  input  logic [WORD-1:0] alu_out,
  input  logic [3:0]      alu_status
);

  localparam int CW = $clog2(WORD);
  localparam logic [CW-1:0] LAST = CW'(WORD - 1);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [WORD-1:0] m, acc, q;
  logic [CW-1:0]   cnt;
  logic [WORD-1:0] acc_nxt, q_nxt;
  logic            step;
  logic            unused_status;

  // Only the carry is needed; it is the (WORD+1)th bit of the partial product.
  assign unused_status = ^alu_status[3:1];
  assign acc_nxt = {alu_status[0], alu_out[WORD-1:1]};
  assign q_nxt   = {alu_out[0], q[WORD-1:1]};
  assign step    = (state == RUN) && alu_gnt && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        m   <= op_a;
        q   <= op_b;
        acc <= '0;
        cnt <= '0;
      end else if (step) begin
        acc <= acc_nxt;
        q   <= q_nxt;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          prod_hi <= acc_nxt;
          prod_lo <= q_nxt;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_req   = 1'b0;
    alu_op    = OP_ADD;
    alu_a     = '0;
    alu_b     = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = WAIT_GNT;
      end
      WAIT_GNT: begin
        busy    = 1'b1;
        alu_req = 1'b1;
        if (abort)        state_nxt = IDLE;
        else if (alu_gnt) state_nxt = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        alu_req = 1'b1;
        alu_a   = acc;
        alu_b   = q[0] ? m : '0;
        if (abort)                     state_nxt = IDLE;
        else if (step && cnt == LAST)  state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU adder and scripted grant.
// Inputs change and outputs are sampled 1ns after each rising edge; the accept edge is counted as edge 0.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, alu_gnt;
  logic [15:0] op_a, op_b, prod_hi, prod_lo, alu_a, alu_b, alu_out;
  logic [3:0]  alu_op, alu_status;
  logic        busy, done, alu_req, carry;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Shared ALU stand-in: combinational ADD reporting carry in status bit 0.
  assign {carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_status       = {3'b000, carry};

  alu_mul_sequencer #(.WORD(16), .OP_ADD(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .prod_hi(prod_hi), .prod_lo(prod_lo), .alu_req(alu_req), .alu_gnt(alu_gnt),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .alu_status(alu_status)
  );

  task automatic do_start(input logic [15:0] a, input logic [15:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the edge index (accept edge = 0) after which done was seen, or -1.
  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; alu_gnt = 1'b1;
    op_a = '0; op_b = '0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, alu_req} !== 3'b000 || alu_op !== 4'd0 ||
        {prod_hi, prod_lo, alu_a, alu_b} !== 64'd0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b req=%b op=%h prod=%h_%h a=%h b=%h, want all zero",
               busy, done, alu_req, alu_op, prod_hi, prod_lo, alu_a, alu_b);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_small;
    int cyc;
    do_start(16'd3, 16'd5);
    tests++;
    if (busy !== 1'b1 || alu_req !== 1'b1) begin
      fails++;
      $display("FAIL small_busy: busy=%b req=%b, want 1 1", busy, alu_req);
    end
    wait_done(60, cyc);
    tests++;
    if (cyc != 17) begin
      fails++;
      $display("FAIL small_latency: done after edge %0d, want 17 (cycle 18)", cyc);
    end
    tests++;
    if (prod_hi !== 16'h0000 || prod_lo !== 16'h000F || alu_req !== 1'b0) begin
      fails++;
      $display("FAIL small_prod: prod=%h_%h req=%b, want 0000_000f req 0", prod_hi, prod_lo, alu_req);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL small_pulse: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_carry;
    int cyc;
    do_start(16'hFFFF, 16'hFFFF);
    wait_done(60, cyc);
    tests++;
    if (cyc != 17 || prod_hi !== 16'hFFFE || prod_lo !== 16'h0001) begin
      fails++;
      $display("FAIL carry_prod: edge=%0d prod=%h_%h, want 17 fffe_0001", cyc, prod_hi, prod_lo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_mult;
    int cyc = -1;
    bit bad_b = 1'b0;
    do_start(16'h1234, 16'h0000);
    for (int k = 1; k <= 60; k++) begin
      if (alu_b !== 16'h0000) bad_b = 1'b1;
      @(posedge clk); #1;
      if (done) begin
        cyc = k;
        break;
      end
    end
    tests++;
    if (bad_b) begin
      fails++;
      $display("FAIL zero_alu_b: alu_b was nonzero during RUN, want 0000");
    end
    tests++;
    if (cyc != 17 || {prod_hi, prod_lo} !== 32'd0) begin
      fails++;
      $display("FAIL zero_prod: edge=%0d prod=%h_%h, want 17 0000_0000", cyc, prod_hi, prod_lo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_preempt;
    int cyc = -1;
    bit req_drop = 1'b0;
    do_start(16'h00AB, 16'h0100);
    alu_gnt = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = k;
        break;
      end
      if (alu_req !== 1'b1) req_drop = 1'b1;
      // grant for edge k+1: low for edges 1..5 and 9..11
      alu_gnt = !(((k + 1) >= 1 && (k + 1) <= 5) || ((k + 1) >= 9 && (k + 1) <= 11));
    end
    alu_gnt = 1'b1;
    tests++;
    if (req_drop) begin
      fails++;
      $display("FAIL preempt_req: alu_req dropped while waiting or stalled, want held 1");
    end
    tests++;
    if (cyc != 25) begin
      fails++;
      $display("FAIL preempt_latency: done after edge %0d, want 25", cyc);
    end
    tests++;
    if (prod_hi !== 16'h0000 || prod_lo !== 16'hAB00) begin
      fails++;
      $display("FAIL preempt_prod: prod=%h_%h, want 0000_ab00", prod_hi, prod_lo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    bit saw_done = 1'b0;
    do_start(16'd7, 16'd9);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      start = (k == 2);
      op_a  = 16'hFFFF;
      op_b  = 16'hFFFF;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || alu_req !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: busy=%b req=%b, want 0 0", busy, alu_req);
    end
    for (int k = 0; k < 30; k++) begin
      if (done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    tests++;
    if (saw_done || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_done: saw_done=%b busy=%b, want 0 0", saw_done, busy);
    end
    tests++;
    if (prod_hi !== 16'h0000 || prod_lo !== 16'hAB00) begin
      fails++;
      $display("FAIL abort_keep_prod: prod=%h_%h, want 0000_ab00", prod_hi, prod_lo);
    end
  endtask

  task automatic test_start_ignored;
    int cyc = -1;
    do_start(16'd3, 16'd5);
    for (int k = 1; k <= 60; k++) begin
      start = (k < 10);
      op_a  = 16'hFFFF;
      op_b  = 16'hFFFF;
      @(posedge clk); #1;
      if (done) begin
        cyc = k;
        break;
      end
    end
    start = 1'b0;
    tests++;
    if (cyc != 17 || prod_hi !== 16'h0000 || prod_lo !== 16'h000F) begin
      fails++;
      $display("FAIL busy_start_ignored: edge=%0d prod=%h_%h, want 17 0000_000f", cyc, prod_hi, prod_lo);
    end
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_no_queue: busy=%b after done, want 0", busy);
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    do_start(16'hFFFF, 16'hFFFF);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, alu_req} !== 3'b000 || alu_op !== 4'd0 ||
        {prod_hi, prod_lo, alu_a, alu_b} !== 64'd0) begin
      fails++;
      $display("FAIL midrun_reset: busy=%b done=%b req=%b op=%h prod=%h_%h a=%h b=%h, want all zero",
               busy, done, alu_req, alu_op, prod_hi, prod_lo, alu_a, alu_b);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_start(16'h1234, 16'h5678);
    wait_done(60, cyc);
    tests++;
    if (cyc != 17 || prod_hi !== 16'h0626 || prod_lo !== 16'h0060) begin
      fails++;
      $display("FAIL post_reset_prod: edge=%0d prod=%h_%h, want 17 0626_0060", cyc, prod_hi, prod_lo);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_small();
    test_carry();
    test_zero_mult();
    test_preempt();
    test_abort();
    test_start_ignored();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
